asu_riscv_divider: RTL and testbench

ASU_RISCV_DIVIDER -- requirements
Module: asu_riscv_divider

---
 rtl/asu_riscv_divider_if.sv | 25 ++
 rtl/asu_riscv_divider.sv | 149 ++++++++++++++
 tb/tb_asu_riscv_divider.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/asu_riscv_divider_if.sv
// Handshake and operand bundle between the mul/div issue logic and the divider.
interface asu_riscv_divider_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            kill_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Issuing side: drives the request, observes completion.
  modport master (
    output start_i, kill_i, div_op_i, op_a_i, op_b_i,
    input  ready_o, done_o, result_o
  );

  // Divider side.
  modport slave (
    input  start_i, kill_i, div_op_i, op_a_i, op_b_i,
    output ready_o, done_o, result_o
  );
endinterface

// File: rtl/asu_riscv_divider.sv
// Iterative RV32M divider: one restoring radix-2 step per cycle on operand
// magnitudes, followed by a sign-fix cycle. Divide-by-zero and signed
// overflow are resolved at acceptance and complete on the next cycle.
module asu_riscv_divider #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               nrst,
  asu_riscv_divider_if.slave bus
);

  localparam int                 CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]    MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]    ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  result_q;

  // Two's-complement magnitude of a value when treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation used by the sign-fix step.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                             input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Acceptance and special-case detection on the incoming request.
  logic            op_signed;
  logic            accept;
  logic            div_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign op_signed = ~bus.div_op_i[0];
  assign accept    = (state == IDLE) & bus.start_i & ~bus.kill_i;
  assign div_zero  = (bus.op_b_i == '0);
  assign sgn_ovf   = op_signed & (bus.op_a_i == MIN_INT) & (bus.op_b_i == ALL_ONES);
  assign special   = div_zero | sgn_ovf;

  // DIV/DIVU by zero give all ones, REM/REMU give the dividend;
  // signed overflow gives MIN_INT quotient and zero remainder.
  assign special_res = div_zero ? (bus.div_op_i[1] ? bus.op_a_i : ALL_ONES)
                                : (bus.div_op_i[1] ? '0 : MIN_INT);

  // One restoring step: 33-bit subtract of the divisor from the shifted
  // partial remainder; the borrow out decides the quotient bit.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            borrow;
  logic [XLEN-1:0] rem_step;
  logic            unused_diff_msb;

  assign shifted         = {rem_q, quo_q[XLEN-1]};
  assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor_q};
  assign rem_step        = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  // When no borrow occurs the difference is below the divisor, so its MSB is zero.
  assign unused_diff_msb = diff[XLEN];

  // Sign-corrected results for the fix cycle.
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;

  assign fix_quo = neg_if(quo_q, sign_a_q ^ sign_b_q);
  assign fix_rem = neg_if(rem_q, sign_a_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; kill overrides every transition.
  always_comb begin
    state_nxt   = state;
    bus.ready_o = 1'b0;
    bus.done_o  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: if (count_q == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.kill_i) state_nxt = IDLE;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.div_op_i;
            sign_a_q  <= op_signed & bus.op_a_i[XLEN-1];
            sign_b_q  <= op_signed & bus.op_b_i[XLEN-1];
            divisor_q <= mag(bus.op_b_i, op_signed);
            quo_q     <= mag(bus.op_a_i, op_signed);
            rem_q     <= '0;
            count_q   <= '0;
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          rem_q   <= rem_step;
          quo_q   <= {quo_q[XLEN-2:0], ~borrow};
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          if (!bus.kill_i) result_q <= op_q[1] ? fix_rem : fix_quo;
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result_q;

endmodule

// File: tb/tb_asu_riscv_divider.sv
// Self-checking bench for asu_riscv_divider: directed RV32M corner cases,
// handshake/kill/reset behaviour and randomized operations against an
// arithmetic reference model.
module tb_asu_riscv_divider;

  logic clk = 1'b0;
  logic nrst;

  asu_riscv_divider_if bus ();

  asu_riscv_divider dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RV32M division semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic            ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done_o or the cycle limit; cyc is the current cycle index.
  task automatic wait_done(input int from, input int limit, output int at);
    int c = from;
    while (!bus.done_o && c < limit) begin
      tick();
      c++;
    end
    at = c;
  endtask

  // Issue one operation in the current cycle (cycle 0) and check it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int at;
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    bus.start_i  = 1'b1;
    bus.div_op_i = op;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    tick();
    bus.start_i  = 1'b0;
    bus.div_op_i = 2'($urandom);
    bus.op_a_i   = $urandom;
    bus.op_b_i   = $urandom;
    wait_done(1, 40, at);
    check({tag, "_lat"}, 32'(at), 32'(exp_lat));
    check({tag, "_res"}, bus.result_o, exp_res);
    tick();
    check({tag, "_post"}, {30'd0, bus.done_o, bus.ready_o}, 32'b01);
  endtask

  initial begin
    int          at;
    int          bad;
    int          pulses;
    logic [31:0] prev;
    logic [1:0]  op;
    logic [31:0] a, b;

    nrst         = 1'b0;
    bus.start_i  = 1'b0;
    bus.kill_i   = 1'b0;
    bus.div_op_i = 2'b00;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    check("rst_ready",  32'(bus.ready_o), 32'd1);
    check("rst_done",   32'(bus.done_o),  32'd0);
    check("rst_result", bus.result_o,     32'h0);

    // Directed arithmetic and special cases.
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("divu_max_3", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);

    // start_i held high with operands changing while busy.
    bus.start_i  = 1'b1;
    bus.div_op_i = 2'b01;
    bus.op_a_i   = 32'd9;
    bus.op_b_i   = 32'd3;
    tick();
    at  = 1;
    bad = 0;
    while (!bus.done_o && at < 40) begin
      if (bus.ready_o) bad++;
      bus.div_op_i = 2'($urandom);
      bus.op_a_i   = $urandom;
      bus.op_b_i   = $urandom;
      tick();
      at++;
    end
    check("hold_lat",  32'(at), 32'd34);
    check("hold_res",  bus.result_o, 32'd3);
    check("hold_busy", 32'(bad), 32'd0);
    bus.div_op_i = 2'b01;
    bus.op_a_i   = 32'd50;
    bus.op_b_i   = 32'd6;
    tick();
    check("hold_ready35", {30'd0, bus.done_o, bus.ready_o}, 32'b01);
    tick();
    bus.start_i = 1'b0;
    wait_done(36, 80, at);
    check("hold2_lat", 32'(at), 32'd69);
    check("hold2_res", bus.result_o, 32'd8);
    tick();

    // kill_i at cycle 10 of DIVU 100/7.
    prev         = bus.result_o;
    bus.start_i  = 1'b1;
    bus.div_op_i = 2'b01;
    bus.op_a_i   = 32'd100;
    bus.op_b_i   = 32'd7;
    tick();
    bus.start_i = 1'b0;
    repeat (9) tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    check("kill_ready", {30'd0, bus.done_o, bus.ready_o}, 32'b01);
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.done_o) pulses++;
    end
    check("kill_nodone", 32'(pulses), 32'd0);
    check("kill_result", bus.result_o, prev);

    // kill_i and start_i together in IDLE: start is dropped.
    bus.start_i  = 1'b1;
    bus.kill_i   = 1'b1;
    bus.div_op_i = 2'b00;
    bus.op_a_i   = 32'd5;
    bus.op_b_i   = 32'd0;
    tick();
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    check("ks_ready", 32'(bus.ready_o), 32'd1);
    pulses = 0;
    repeat (5) begin
      if (bus.done_o) pulses++;
      tick();
    end
    check("ks_nodone", 32'(pulses), 32'd0);
    check("ks_result", bus.result_o, prev);

    // Reset asserted at cycle 20 of an operation.
    run_op("pre_rst", 2'b01, 32'd1000, 32'd10, 32'd100, 34);
    bus.start_i  = 1'b1;
    bus.div_op_i = 2'b01;
    bus.op_a_i   = 32'd100;
    bus.op_b_i   = 32'd7;
    tick();
    bus.start_i = 1'b0;
    repeat (19) tick();
    nrst = 1'b0;
    tick();
    check("rst_mid_done",   32'(bus.done_o), 32'd0);
    check("rst_mid_result", bus.result_o,    32'h0);
    nrst = 1'b1;
    tick();
    check("rst_mid_ready",  32'(bus.ready_o), 32'd1);
    pulses = 0;
    repeat (40) begin
      if (bus.done_o) pulses++;
      tick();
    end
    check("rst_mid_nodone", 32'(pulses), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
        4:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, model(op, a, b), model_lat(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
